// File: rtl/freq_meter.sv
// Input-capture frequency meter: measures period, high time and rising-edge count of an async square wave.
// Optional high-time measurement is built when FREQ_METER_DUTY_EN is defined.
module freq_meter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_cpu,
    input  logic [31:2] Addr,
    input  logic [31:0] Din,
    input  logic        WE,
    output logic [31:0] Dout,
    input  logic        sig,
    output logic        irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                sig_q;
    logic                clk_cpu_q;
    logic [1:0]          ctrl_q;
    logic [DW-1:0]       period_q, edges_q, timeout_q, cnt_q, high_rd;
    logic                valid_q, tmo_q, new_q;

    logic [AW-1:0]       addr;
    logic                wr, ctrl_wr, timeout_wr, status_wr;
    logic                rise, tmo_hit;
    logic [DW-1:0]       cnt_inc;
    logic                rearm, stop, arm_rise, meas_rise, tmo_fire;
    logic                unused_addr;

    assign addr        = Addr[4:2];
    assign unused_addr = &{1'b0, Addr[31:5]};

    // One commit per slow-clock rising edge seen in the clk domain
    assign wr         = WE & clk_cpu & ~clk_cpu_q;
    assign ctrl_wr    = wr && (addr == AW'(0));
    assign timeout_wr = wr && (addr == AW'(4));
    assign status_wr  = wr && (addr == AW'(5));

    assign rise    = sync_q[SYNC_STAGES-1] & ~sig_q;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + DW'(1);
    assign tmo_hit = (timeout_q != '0) &&
                     (({1'b0, cnt_q} + 33'd1) == {1'b0, timeout_q});

    // Input synchronizer and edge register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sig_q     <= 1'b0;
            clk_cpu_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig};
            sig_q     <= sync_q[SYNC_STAGES-1];
            clk_cpu_q <= clk_cpu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // CTRL writes take priority over rise and timeout events
    always_comb begin
        state_d   = state_q;
        rearm     = 1'b0;
        stop      = 1'b0;
        arm_rise  = 1'b0;
        meas_rise = 1'b0;
        tmo_fire  = 1'b0;
        if (ctrl_wr) begin
            if (Din[0]) begin
                rearm   = 1'b1;
                state_d = ARM;
            end else begin
                stop    = 1'b1;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        arm_rise = 1'b1;
                        state_d  = MEAS;
                    end else if (tmo_hit) begin
                        tmo_fire = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        meas_rise = 1'b1;
                    end else if (tmo_hit) begin
                        tmo_fire = 1'b1;
                        state_d  = ARM;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            timeout_q <= DEFAULT_TIMEOUT;
            period_q  <= '0;
            edges_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            new_q     <= 1'b0;
        end else begin
            if (ctrl_wr)    ctrl_q    <= Din[1:0];
            if (timeout_wr) timeout_q <= Din;

            if (rearm || arm_rise || meas_rise || tmo_fire) cnt_q <= '0;
            else if (state_q != IDLE && !stop)              cnt_q <= cnt_inc;

            if (rearm)                      edges_q <= '0;
            else if (arm_rise || meas_rise) edges_q <= edges_q + DW'(1);

            if (meas_rise) period_q <= cnt_inc;

            if (rearm || tmo_fire) valid_q <= 1'b0;
            else if (meas_rise)    valid_q <= 1'b1;

            // Hardware set beats a same-cycle W1C
            if (rearm)                       new_q <= 1'b0;
            else if (meas_rise)              new_q <= 1'b1;
            else if (status_wr && Din[2])    new_q <= 1'b0;

            if (rearm)                       tmo_q <= 1'b0;
            else if (tmo_fire)               tmo_q <= 1'b1;
            else if (status_wr && Din[1])    tmo_q <= 1'b0;
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic          fall;
    logic          fall_seen_q;
    logic [DW-1:0] hi_lat_q, high_q;

    assign fall = ~sync_q[SYNC_STAGES-1] & sig_q;

    // A period with no observed fall reports HIGH equal to PERIOD
    always_ff @(posedge clk) begin
        if (rst) begin
            fall_seen_q <= 1'b0;
            hi_lat_q    <= '0;
            high_q      <= '0;
        end else begin
            if (rearm || arm_rise || meas_rise)  fall_seen_q <= 1'b0;
            else if (fall && state_q != IDLE)    fall_seen_q <= 1'b1;
            if (fall && state_q != IDLE) hi_lat_q <= cnt_inc;
            if (meas_rise) high_q <= fall_seen_q ? hi_lat_q : cnt_inc;
        end
    end

    assign high_rd = high_q;
`else
    assign high_rd = '0;
`endif

    always_comb begin
        Dout = '0;
        case (addr)
            AW'(0): Dout = {30'b0, ctrl_q};
            AW'(1): Dout = period_q;
            AW'(2): Dout = high_rd;
            AW'(3): Dout = edges_q;
            AW'(4): Dout = timeout_q;
            AW'(5): Dout = {29'b0, new_q, tmo_q, valid_q};
            default: Dout = '0;
        endcase
    end

    assign irq = ctrl_q[1] & new_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: register table, directed corner sequences and randomized
// square waves checked against a period/high/edge-count model.
module tb_freq_meter;

`ifdef FREQ_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_cpu;
    logic [31:2] Addr;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] Dout;
    logic        sig;
    logic        irq;

    int passed = 0;
    int total  = 0;

    freq_meter dut (
        .clk    (clk),
        .rst    (rst),
        .clk_cpu(clk_cpu),
        .Addr   (Addr),
        .Din    (Din),
        .WE     (WE),
        .Dout   (Dout),
        .sig    (sig),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[16];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        else passed++;
    endtask

    task automatic chk_reg(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        Addr = 30'(a);
        #1 v = Dout;
        chk(nm, v, exp);
    endtask

    // Called on a negedge; commit lands on the second following posedge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        Addr = 30'(a); Din = d; WE = 1'b1; clk_cpu = 1'b0;
        tick(1);
        clk_cpu = 1'b1;
        tick(1);
        WE = 1'b0; clk_cpu = 1'b0;
    endtask

    task automatic pulse_train(input int h, input int l, input int n);
        repeat (n) begin
            sig = 1'b1; tick(h);
            sig = 1'b0; tick(l);
        end
    endtask

    initial begin
        int hq[$];
        int lq[$];
        int n;
        logic ie;

        rst = 1'b1; clk_cpu = 1'b0; Addr = '0; Din = '0; WE = 1'b0; sig = 1'b0;

        vt[0]  = '{"rst_ctrl",    3'd0, 1'b0, 32'h0, 32'h0};
        vt[1]  = '{"rst_period",  3'd1, 1'b0, 32'h0, 32'h0};
        vt[2]  = '{"rst_high",    3'd2, 1'b0, 32'h0, 32'h0};
        vt[3]  = '{"rst_edges",   3'd3, 1'b0, 32'h0, 32'h0};
        vt[4]  = '{"rst_timeout", 3'd4, 1'b0, 32'h0, 32'd50_000_000};
        vt[5]  = '{"rst_status",  3'd5, 1'b0, 32'h0, 32'h0};
        vt[6]  = '{"rst_hole6",   3'd6, 1'b0, 32'h0, 32'h0};
        vt[7]  = '{"rst_hole7",   3'd7, 1'b0, 32'h0, 32'h0};
        vt[8]  = '{"timeout_rw",  3'd4, 1'b1, 32'h0000_1234, 32'h0000_1234};
        vt[9]  = '{"ctrl_mask",   3'd0, 1'b1, 32'hFFFF_FFFE, 32'h2};
        vt[10] = '{"period_ro",   3'd1, 1'b1, 32'h5, 32'h0};
        vt[11] = '{"high_ro",     3'd2, 1'b1, 32'h3, 32'h0};
        vt[12] = '{"edges_ro",    3'd3, 1'b1, 32'h9, 32'h0};
        vt[13] = '{"hole6_wr",    3'd6, 1'b1, 32'hFF, 32'h0};
        vt[14] = '{"status_idle", 3'd5, 1'b1, 32'h7, 32'h0};
        vt[15] = '{"timeout_rst", 3'd4, 1'b1, 32'd50_000_000, 32'd50_000_000};

        tick(3);
        rst = 1'b0;
        tick(1);

        // Register table
        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].wdata);
            chk_reg(vt[i].nm, vt[i].addr, vt[i].exp);
        end
        chk("rst_irq", 32'(irq), 32'h0);
        bus_write(3'd0, 32'h0);

        // Basic measurement 100/30
        bus_write(3'd0, 32'h3);
        pulse_train(30, 70, 3);
        chk_reg("a_period", 3'd1, 32'd100);
        chk_reg("a_high",   3'd2, DUTY ? 32'd30 : 32'd0);
        chk_reg("a_edges",  3'd3, 32'd3);
        chk_reg("a_status", 3'd5, 32'h5);
        chk("a_irq", 32'(irq), 32'h1);
        bus_write(3'd5, 32'h4);
        chk_reg("a_status_w1c", 3'd5, 32'h1);
        chk("a_irq_clr", 32'(irq), 32'h0);

        // Timeout 500 cycles after arm, then recovery
        bus_write(3'd4, 32'd500);
        bus_write(3'd0, 32'h1);
        tick(499);
        chk_reg("b_tmo_early", 3'd5, 32'h0);
        tick(1);
        chk_reg("b_tmo_set", 3'd5, 32'h2);
        pulse_train(100, 100, 1);
        sig = 1'b1;
        tick(10);
        chk_reg("b_period", 3'd1, 32'd200);
        chk_reg("b_high",   3'd2, DUTY ? 32'd100 : 32'd0);
        chk_reg("b_edges",  3'd3, 32'd2);
        chk_reg("b_status", 3'd5, 32'h7);
        chk("b_irq_masked", 32'(irq), 32'h0);

        // W1C of NEW colliding with a rise
        bus_write(3'd4, 32'h0);
        sig = 1'b0;
        tick(50);
        bus_write(3'd5, 32'h4);
        chk_reg("c_new_clr", 3'd5, 32'h3);
        sig = 1'b1;
        tick(1);
        Addr = 30'd5; Din = 32'h4; WE = 1'b1; clk_cpu = 1'b0;
        tick(1);
        clk_cpu = 1'b1;
        tick(1);
        WE = 1'b0; clk_cpu = 1'b0;
        chk_reg("c_new_wins", 3'd5, 32'h7);
        sig = 1'b0;
        tick(40);
        sig = 1'b1;
        tick(2);
        bus_write(3'd5, 32'h4);
        chk_reg("c_w1c_after", 3'd5, 32'h3);

        // Stop mid-measurement
        sig = 1'b0;
        tick(10);
        bus_write(3'd0, 32'h3);
        pulse_train(40, 60, 3);
        chk_reg("d_edges_pre", 3'd3, 32'd3);
        sig = 1'b1;
        tick(20);
        bus_write(3'd0, 32'h0);
        tick(5);
        pulse_train(10, 20, 4);
        tick(10);
        chk_reg("d_ctrl",   3'd0, 32'h0);
        chk_reg("d_period", 3'd1, 32'd100);
        chk_reg("d_high",   3'd2, DUTY ? 32'd40 : 32'd0);
        chk_reg("d_edges",  3'd3, 32'd4);
        chk_reg("d_status", 3'd5, 32'h5);
        chk("d_irq", 32'(irq), 32'h0);

        // WE without a slow-clock edge must not commit
        Addr = 30'd0; Din = 32'h3; WE = 1'b1; clk_cpu = 1'b0;
        tick(50);
        WE = 1'b0;
        chk_reg("e_ctrl",  3'd0, 32'h0);
        chk_reg("e_edges", 3'd3, 32'd4);

        // Reset during MEAS
        bus_write(3'd0, 32'h3);
        pulse_train(25, 25, 3);
        chk_reg("f_edges", 3'd3, 32'd3);
        chk("f_irq_pre", 32'(irq), 32'h1);
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) chk_reg({"f_", vt[i].nm}, vt[i].addr, vt[i].exp);
        chk("f_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick(2);

        // Randomized square waves against the period/high/edge model
        for (int it = 0; it < 8; it++) begin
            hq.delete();
            lq.delete();
            ie = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                hq.push_back(int'($urandom_range(2, 20)));
                lq.push_back(int'($urandom_range(2, 20)));
            end
            bus_write(3'd0, {30'b0, ie, 1'b1});
            tick(int'($urandom_range(3, 8)));
            for (int k = 0; k < n; k++) pulse_train(hq[k], lq[k], 1);
            sig = 1'b1;
            tick(6);
            chk_reg($sformatf("r%0d_period", it), 3'd1, 32'(hq[n-1] + lq[n-1]));
            chk_reg($sformatf("r%0d_high", it),   3'd2, DUTY ? 32'(hq[n-1]) : 32'd0);
            chk_reg($sformatf("r%0d_edges", it),  3'd3, 32'(n + 1));
            chk_reg($sformatf("r%0d_status", it), 3'd5, 32'h5);
            chk($sformatf("r%0d_irq", it), 32'(irq), 32'(ie));
            sig = 1'b0;
            tick(6);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
